ibex_mem_responder: RTL

- Memory-side responder for the Ibex req/gnt/rvalid OBI-style bus.
- One instance serves one port: the instruction port (we_i tied 0) or the data port. It drives the core's instruction or data memory inputs in the cocotb testbench top.
- Word-addressed SRAM model with fixed response latency, bounded outstanding requests, byte-enable writes, and an error response for out-of-window addresses.

---
 rtl/ibex_mem_responder_pkg.sv | 27 ++
 rtl/ibex_mem_resp_pipe.sv | 45 ++++
 rtl/ibex_mem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ibex_mem_responder_pkg.sv
// Shared types and helpers for the Ibex memory responder.
//   resp_t      : response payload carried through the latency pipe
//   LFSR_TAPS   : feedback taps of the 16-bit stall LFSR (bits 16,14,13,11)
//   be_to_mask  : expands 4 byte enables into a 32-bit write mask
package ibex_mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < int'(BE_W); k++) begin
      mask[8*k +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line with synchronous clear.
// Ports:
//   clk        clock
//   clr        synchronous clear, drops every in-flight entry
//   in_valid   entry captured this cycle
//   in_resp    payload captured with in_valid
//   out_valid  entry leaving the pipe, Depth cycles after capture
//   out_resp   payload of the leaving entry, zero when out_valid is 0
module ibex_mem_resp_pipe
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  in_valid,
  input  resp_t in_resp,
  output logic  out_valid,
  output resp_t out_resp
);

  logic [Depth-1:0] valid_q;
  resp_t            resp_q [Depth];

  // Empty slots carry a zero payload so the output is clean whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int s = 0; s < int'(Depth); s++) begin
        resp_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      resp_q[0]  <= in_valid ? in_resp : '0;
      for (int s = 1; s < int'(Depth); s++) begin
        valid_q[s] <= valid_q[s-1];
        resp_q[s]  <= resp_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_resp  = resp_q[Depth-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word-addressed SRAM
// model with fixed response latency, bounded outstanding requests, byte-enable
// writes and an error response outside the address window.
// Optional build macro: IBEX_MEM_RESPONDER_STALL_EN adds LFSR-driven grant stalls.
// Ports:
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   req_i     request, attributes held until granted
//   gnt_o     request accepted this cycle (combinational)
//   rvalid_o  response valid, one cycle per grant
//   we_i      write enable
//   be_i      byte enables
//   addr_i    byte address, bits [1:0] ignored
//   wdata_i   write data
//   rdata_o   read data, zero unless rvalid_o
//   err_o     bus error, zero unless rvalid_o
module ibex_mem_responder
  import ibex_mem_responder_pkg::*;
#(
  parameter logic [31:0]       AddrBase       = 32'h00100000,
  parameter int unsigned       MemWords       = 4096,
  parameter int unsigned       RespLatency    = 1,
  parameter int unsigned       MaxOutstanding = 2,
  parameter logic [LFSR_W-1:0] LfsrSeed       = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(MemWords);
  localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);

  logic [DATA_W-1:0] mem [MemWords];

  logic [CNT_W-1:0]  outstanding_q;
  logic [29:0]       word_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              slot_free;
  logic [DATA_W-1:0] wmask;
  resp_t             grant_resp;
  resp_t             pipe_resp;
  logic              pipe_valid;

  // Word offset from the window base; the full 30-bit offset guards the upper bound.
  assign word_off  = addr_i[31:2] - AddrBase[31:2];
  assign idx       = word_off[IDX_W-1:0];
  assign in_range  = (addr_i >= AddrBase) && (word_off < 30'(MemWords));
  assign slot_free = outstanding_q < CNT_W'(MaxOutstanding);
  assign wmask     = be_to_mask(be_i);

`ifdef IBEX_MEM_RESPONDER_STALL_EN
  logic [LFSR_W-1:0] lfsr_q;

  // Fibonacci LFSR, advances every cycle; low bits 00 stall the grant (~25%).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign gnt_o = req_i && !rst_i && slot_free && (lfsr_q[1:0] != 2'b00);
`else
  assign gnt_o = req_i && !rst_i && slot_free;
`endif

  // Byte-lane write at the edge ending the grant cycle.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata_i & wmask);
    end
  end

  // Response captured in the grant cycle: read data, zero for writes, error out of window.
  always_comb begin
    grant_resp = '0;
    if (!in_range) begin
      grant_resp.err = 1'b1;
    end else if (!we_i) begin
      grant_resp.rdata = mem[idx];
    end
  end

  ibex_mem_resp_pipe #(
    .Depth (RespLatency)
  ) u_pipe (
    .clk       (clk_i),
    .clr       (rst_i),
    .in_valid  (gnt_o),
    .in_resp   (grant_resp),
    .out_valid (pipe_valid),
    .out_resp  (pipe_resp)
  );

  assign rvalid_o = pipe_valid;
  assign rdata_o  = pipe_resp.rdata;
  assign err_o    = pipe_resp.err;

  // Granted-but-unanswered count; simultaneous grant and retire cancel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (gnt_o && !rvalid_o) begin
      outstanding_q <= outstanding_q + CNT_W'(1);
    end else if (!gnt_o && rvalid_o) begin
      outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

endmodule
